max_joltager_kdigit: RTL

Streaming selector for one battery bank. It returns the largest NUM_DIGITS-digit number formed by keeping NUM_DIGITS of the bank's digits in their original order. The selection count is parametrised: NUM_DIGITS=2 is the two-digit case and NUM_DIGITS=12 is the extended case. One instance serves one bank lane, and lanes are replicated and summed downstream. It adds valid/ready handshaking, bank delimiting and a short-bank flag, so back-to-back banks stream without a reset.

---
 rtl/max_joltager_kdigit.sv | 63 ++++++
 1 files changed

// File: rtl/max_joltager_kdigit.sv
// max_joltager_kdigit: streaming selector of the largest K-digit ordered subsequence of a BCD digit bank.
module max_joltager_kdigit #(
  parameter int NUM_DIGITS   = 12,
  parameter int MAX_BANK_LEN = 255,
  parameter int LEN_W        = $clog2(MAX_BANK_LEN + 1)
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [3:0]              in_digit,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [4*NUM_DIGITS-1:0] out_joltage_bcd,
  output logic [LEN_W-1:0]        out_len,
  output logic                    out_short
);
  localparam int W = 4 * NUM_DIGITS;
  // best[j] holds a j-digit value zero-extended to W bits; best[0] is the empty string
  logic [W-1:0] best   [NUM_DIGITS+1];
  logic [W-1:0] best_n [NUM_DIGITS+1];
  logic [W-1:0] cand;
  logic [LEN_W-1:0] len, len_n;
  logic acc, upd, bank_end, short_n;
  assign in_ready = !out_valid || out_ready;
  assign acc      = in_valid && in_ready;
  assign upd      = acc && (in_digit <= 4'd9);
  assign bank_end = acc && in_last;
  assign short_n  = int'(len_n) < NUM_DIGITS;
  always_comb begin
    len_n     = (upd && int'(len) < MAX_BANK_LEN) ? len + 1'b1 : len;
    best_n[0] = '0;
    cand      = '0;
    for (int j = 1; j <= NUM_DIGITS; j++) begin
      cand      = (best[j-1] << 4) | W'(in_digit);
      best_n[j] = !upd                                ? best[j] :
                  (int'(len) == j - 1)                ? cand    :
                  (int'(len) >= j && cand > best[j])  ? cand    : best[j];
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int j = 0; j <= NUM_DIGITS; j++) best[j] <= '0;
      len             <= '0;
      out_valid       <= 1'b0;
      out_joltage_bcd <= '0;
      out_len         <= '0;
      out_short       <= 1'b0;
    end else begin
      for (int j = 1; j <= NUM_DIGITS; j++) best[j] <= bank_end ? '0 : best_n[j];
      len <= bank_end ? '0 : len_n;
      if (bank_end) begin
        out_valid       <= 1'b1;
        out_joltage_bcd <= short_n ? '0 : best_n[NUM_DIGITS];
        out_len         <= len_n;
        out_short       <= short_n;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule
